regfile_1w2r_sync_rst: RTL and testbench
========================================

Name: regfile_1w2r_sync_rst

Overview:
- Multi-entry register file: one write port, two independent read ports.
- Registered (1-cycle) read ports, optional write-to-read bypass, optional hardwired-zero entry 0.
- Read-side companion to the enable-gated register primitives; used as CPU/accelerator architectural register storage and CSR banks.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 32, bits per entry.
- DEPTH, 32, number of entries (≥2; need not be a power of 2).
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read; 0 = the read returns the pre-write value.
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are discarded.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- wr_err  output  1  1-cycle pulse: previous-cycle write targeted an address ≥ DEPTH.
- rd0_en  input  1  read strobe, port 0.
- rd0_addr  input  ADDR_W  read address, port 0.
- rd0_data  output  WIDTH  registered read data, port 0.
- rd0_valid  output  1  1-cycle pulse: rd0_data updated by previous-cycle read.
- rd0_err  output  1  1-cycle pulse: previous-cycle port-0 read was out of range.
- rd1_en, rd1_addr, rd1_data, rd1_valid, rd1_err: identical to port 0, for port 1.

Behaviour:
- Reset (rst=1 at posedge):
  - All DEPTH entries ← 0.
  - rd0_data, rd1_data ← 0.
  - All valid and err outputs ← 0.
  - Reset dominates any wr_en/rd*_en in the same cycle: the write is lost and no valid pulse follows.
- Write:
  - On posedge with wr_en=1 and wr_addr<DEPTH, mem[wr_addr] ← wr_data.
  - wr_addr ≥ DEPTH: storage unchanged; wr_err=1 the next cycle for exactly one cycle.
  - ZERO_REG=1 with wr_addr=0: write discarded, no error.
- Read:
  - Latency 1. When rdN_en=1 at posedge k, rdN_data holds the read value and rdN_valid=1 during cycle k+1.
  - rdN_en=0: rdN_data holds its last value; rdN_valid=0.
  - Out-of-range address: rdN_data ← 0, rdN_valid=1, rdN_err=1 for one cycle.
  - ZERO_REG=1 with addr 0: rdN_data ← 0.
- Bypass (same posedge: wr_en=1, rdN_en=1, rdN_addr==wr_addr, address in range and writable):
  - BYPASS=1: rdN_data ← wr_data.
  - BYPASS=0: rdN_data ← old mem value.
  - Storage is updated in either case.
- Ports are independent. Both ports on the same address return identical data. Back-to-back reads every cycle are allowed, giving one result per cycle per port.
- Width rules: no truncation or extension; data is passed bit-exact.
- Storage is flop-based (synchronous reset of every entry), not inferred RAM.

Test Plan:
1. Reset then read: after rst, rd0_en=1, rd0_addr=5 → next cycle rd0_data=0, rd0_valid=1, rd0_err=0.
2. Write/read, latency: write 0xDEADBEEF to addr 3; next cycle rd1_en addr 3 → the following cycle rd1_data=0xDEADBEEF, rd1_valid=1; cycle after that with rd1_en=0 → rd1_valid=0, data held.
3. Bypass: mem[7]=0x11; same cycle wr 7←0x22 and rd0 addr 7 → rd0_data=0x22 (BYPASS=1) or 0x11 (BYPASS=0); subsequent read returns 0x22 in both builds.
4. Out of range, DEPTH=20: wr_addr=25, data 0xAA → wr_err pulses 1 cycle, no entry changed; rd0 addr 25 → rd0_data=0, rd0_valid=1, rd0_err=1.
5. ZERO_REG=1: write 0x55 to addr 0 → wr_err=0; reads on both ports of addr 0 return 0.
6. Reset mid-operation: write addr 2←0x99 and rd1 addr 2 in the same cycle as rst=1 → next cycle rd1_valid=0, rd1_data=0; later read of addr 2 returns 0.

Source files
------------

// File: rtl/regfile_1w2r_sync_rst.sv
// regfile_1w2r_sync_rst: flop-based register file, one write port, two registered read ports
module regfile_1w2r_sync_rst #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_err,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic              rd0_valid,
  output logic              rd0_err,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd1_valid,
  output logic              rd1_err
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra [2];
  logic [1:0] re;
  logic w_ok;
  assign ra[0] = rd0_addr;
  assign ra[1] = rd1_addr;
  assign re = {rd1_en, rd0_en};
  // a write lands only if in range and not aimed at a hardwired-zero entry
  assign w_ok = wr_en && ({1'b0, wr_addr} < LIM) && !(ZERO_REG != 0 && wr_addr == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      if (w_ok) mem[wr_addr] <= wr_data;
      wr_err <= wr_en && ({1'b0, wr_addr} >= LIM);
    end
  end
  for (genvar g = 0; g < 2; g++) begin : port
    logic in_r, byp, v, e;
    logic [WIDTH-1:0] val, q;
    always_comb begin
      in_r = {1'b0, ra[g]} < LIM;
      byp = BYPASS != 0 && w_ok && wr_addr == ra[g];
      val = (!in_r || (ZERO_REG != 0 && ra[g] == '0)) ? '0 : byp ? wr_data : mem[ra[g]];
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
        v <= 1'b0;
        e <= 1'b0;
      end else begin
        v <= re[g];
        e <= re[g] && !in_r;
        if (re[g]) q <= val;
      end
    end
  end
  assign rd0_data = port[0].q;
  assign rd0_valid = port[0].v;
  assign rd0_err = port[0].e;
  assign rd1_data = port[1].q;
  assign rd1_valid = port[1].v;
  assign rd1_err = port[1].e;
endmodule

// File: tb/tb_regfile_1w2r_sync_rst.sv
// tb_regfile_1w2r_sync_rst: scoreboard bench driving two builds (bypass+zero-reg, and neither) in lockstep
module tb_regfile_1w2r_sync_rst;
  logic clk = 1'b0;
  logic rst, wr_en, rd0_en, rd1_en;
  logic [4:0] wr_addr, rd0_addr, rd1_addr;
  logic [31:0] wr_data;
  logic wr_err_a, rd0_valid_a, rd0_err_a, rd1_valid_a, rd1_err_a;
  logic wr_err_b, rd0_valid_b, rd0_err_b, rd1_valid_b, rd1_err_b;
  logic [31:0] rd0_data_a, rd1_data_a, rd0_data_b, rd1_data_b;
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  typedef struct packed {
    int unsigned cyc;
    logic [31:0] da;
    logic [31:0] db;
    logic err;
  } rexp_t;
  rexp_t q0[$];
  rexp_t q1[$];
  int unsigned wq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_1w2r_sync_rst #(.WIDTH(32), .DEPTH(20), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_a),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data_a), .rd0_valid(rd0_valid_a), .rd0_err(rd0_err_a),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data_a), .rd1_valid(rd1_valid_a), .rd1_err(rd1_err_a));

  regfile_1w2r_sync_rst #(.WIDTH(32), .DEPTH(20), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_b),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data_b), .rd0_valid(rd0_valid_b), .rd0_err(rd0_err_b),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data_b), .rd1_valid(rd1_valid_b), .rd1_err(rd1_err_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_rd(input string n, input logic va, vb, input logic [31:0] a, b, input logic ea, eb, input rexp_t e);
    chk({n, "_valid_a"}, {31'b0, va}, 1);
    chk({n, "_valid_b"}, {31'b0, vb}, 1);
    chk({n, "_cycle"}, cyc, e.cyc);
    chk({n, "_data_a"}, a, e.da);
    chk({n, "_data_b"}, b, e.db);
    chk({n, "_err_a"}, {31'b0, ea}, {31'b0, e.err});
    chk({n, "_err_b"}, {31'b0, eb}, {31'b0, e.err});
  endtask

  // monitor: pops one expectation per presented result, independent of the stimulus
  always @(negedge clk) begin
    if (rd0_valid_a || rd0_valid_b) begin
      if (q0.size() == 0) chk("rd0_unexpected_valid", {31'b0, rd0_valid_a | rd0_valid_b}, 0);
      else mon_rd("rd0", rd0_valid_a, rd0_valid_b, rd0_data_a, rd0_data_b, rd0_err_a, rd0_err_b, q0.pop_front());
    end else if (rd0_err_a || rd0_err_b) chk("rd0_err_without_valid", 1, 0);
    if (rd1_valid_a || rd1_valid_b) begin
      if (q1.size() == 0) chk("rd1_unexpected_valid", {31'b0, rd1_valid_a | rd1_valid_b}, 0);
      else mon_rd("rd1", rd1_valid_a, rd1_valid_b, rd1_data_a, rd1_data_b, rd1_err_a, rd1_err_b, q1.pop_front());
    end else if (rd1_err_a || rd1_err_b) chk("rd1_err_without_valid", 1, 0);
    if (wr_err_a || wr_err_b) begin
      if (wq.size() == 0) chk("wr_err_unexpected", {31'b0, wr_err_a | wr_err_b}, 0);
      else begin
        chk("wr_err_cycle", cyc, wq.pop_front());
        chk("wr_err_a", {31'b0, wr_err_a}, 1);
        chk("wr_err_b", {31'b0, wr_err_b}, 1);
      end
    end
  end

  task automatic step(input logic r, we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic r0e, input logic [4:0] r0a, input logic [31:0] x0a, x0b,
                      input logic r1e, input logic [4:0] r1a, input logic [31:0] x1a, x1b);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd0_en = r0e; rd0_addr = r0a; rd1_en = r1e; rd1_addr = r1a;
    if (!r && r0e) q0.push_back('{cyc + 1, x0a, x0b, r0a >= 5'd20});
    if (!r && r1e) q1.push_back('{cyc + 1, x1a, x1b, r1a >= 5'd20});
    if (!r && we && wa >= 5'd20) wq.push_back(cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_rd0_data_a", rd0_data_a, 0);
    chk("reset_rd1_data_b", rd1_data_b, 0);
    chk("reset_flags", {22'b0, wr_err_a, wr_err_b, rd0_valid_a, rd0_valid_b, rd0_err_a, rd0_err_b,
                        rd1_valid_a, rd1_valid_b, rd1_err_a, rd1_err_b}, 0);
    // reset then read
    step(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    // write then read one cycle later, then hold
    step(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF);
    idle();
    chk("hold_rd1_valid", {30'b0, rd1_valid_a, rd1_valid_b}, 0);
    chk("hold_rd1_data_a", rd1_data_a, 32'hDEADBEEF);
    chk("hold_rd1_data_b", rd1_data_b, 32'hDEADBEEF);
    // bypass vs old value
    step(0, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 32'h22, 1, 7, 32'h22, 32'h11, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 32'h22, 32'h22, 1, 7, 32'h22, 32'h22);
    // out of range writes/reads, top valid entry
    step(0, 1, 25, 32'hAA, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 20, 32'hBB, 1, 25, 0, 0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF);
    step(0, 1, 19, 32'h12345678, 1, 7, 32'h22, 32'h22, 1, 20, 0, 0);
    step(0, 0, 0, 0, 1, 19, 32'h12345678, 32'h12345678, 1, 31, 0, 0);
    // entry 0: hardwired zero in build A, ordinary in build B
    step(0, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h66, 1, 0, 0, 32'h55, 1, 0, 0, 32'h55);
    step(0, 0, 0, 0, 1, 0, 0, 32'h66, 1, 0, 0, 32'h66);
    // back-to-back reads on both ports
    step(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 19, 32'h12345678, 32'h12345678);
    step(0, 0, 0, 0, 1, 19, 32'h12345678, 32'h12345678, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF);
    // reset dominates same-cycle write and read
    step(1, 1, 2, 32'h99, 0, 0, 0, 0, 1, 2, 0, 0);
    chk("rst_rd1_valid", {30'b0, rd1_valid_a, rd1_valid_b}, 0);
    chk("rst_rd1_data_a", rd1_data_a, 0);
    chk("rst_rd1_data_b", rd1_data_b, 0);
    step(0, 0, 0, 0, 1, 2, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1, 19, 0, 0, 1, 7, 0, 0);
    idle();
    idle();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1);
  end
endmodule
